heavy_part_table_dump0: RTL and testbench
=========================================

# heavy_part_table_dump0

Read-out engine for heavy-part table 0 of the Elastic Sketch pipeline. On a host command it suspends the update path, scans all 4096 heavy-table RAM entries in address order, and exports every non-empty entry with its bucket index to a downstream collection FIFO. It can optionally zero the table as it scans, starting a new measurement epoch. It is the read side of the entry format that the table-0 compare stage writes.

## Interface
- ADDR_W, 12, table address width (4096 buckets)
- DATA_W, 96, entry width: [95:64] ip addr, [63:32] positive vote, [31:0] negative vote
- RD_LAT, 2, RAM read latency in cycles, from registered rdaddr to valid rdvalue
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- dump_start  in  1  one-cycle start request
- dump_clear  in  1  sampled with dump_start; 1 = zero every entry while scanning
- dump_busy  out  1  high from accepted start until dump_done
- dump_done  out  1  one-cycle completion pulse
- entry_cnt  out  13  number of entries exported by the current or last dump
- table_hold_req  out  1  requests the compare stage to stop issuing RAM writes
- table_hold_ack  in  1  compare stage is idle and holding
- ram_rdaddr  out  12  RAM read address
- ram_rdvalue  in  96  RAM read data
- ram_wren  out  1  RAM write enable (clear mode only)
- ram_wraddr  out  12  RAM write address
- ram_wrvalue  out  96  RAM write data, always 96'b0
- dump_out_wr  out  1  export FIFO write strobe
- dump_out  out  108  {bucket addr[11:0], entry[95:0]}
- dump_out_alf  in  1  export FIFO almost-full

## Operation
- All outputs are registered. Reset value of every output is 0, and the state machine resets to IDLE.
- States and transitions:
  - IDLE → HOLD when dump_start=1. This cycle latches clear_r=dump_clear, zeroes entry_cnt, and sets dump_busy.
  - HOLD: drive table_hold_req=1. Go to SCAN when table_hold_ack=1.
  - SCAN: on each cycle with dump_out_alf=0, issue ram_rdaddr=issue_addr and increment issue_addr. On a cycle with dump_out_alf=1, issue nothing and hold the address. Go to DRAIN in the cycle after address 4095 is issued.
  - DRAIN: wait until the valid pipe is empty, then go to DONE.
  - DONE: pulse dump_done, drop table_hold_req and dump_busy, return to IDLE.
- Valid pipe:
  - A RD_LAT-deep shift register carries {valid, addr} for each issued read.
  - On return, if ram_rdvalue != 96'b0, write dump_out={addr, ram_rdvalue} with dump_out_wr=1 and increment entry_cnt.
  - Zero entries are dropped.
- Clear mode:
  - On every return (zero or not), write ram_wren=1, ram_wraddr=addr, ram_wrvalue=0 in the same cycle as the export.
  - Result: exactly 4096 writes per cleared dump.
- Backpressure:
  - alf stops issue only. In-flight reads still complete and are exported.
  - The downstream FIFO must reserve at least RD_LAT+1 words above its alf threshold.
  - No entry is lost or duplicated across any pause.
- dump_start outside IDLE is ignored. dump_clear is sampled only with an accepted start.
- entry_cnt is 13 bits so that 4096 (a full table) is representable. It holds its value after done until the next start.
- Reset mid-dump: the scan aborts, table_hold_req drops, and no done pulse is generated. Table content is partially cleared if clear mode was active; the host re-issues the dump.
- table_hold_ack dropping during SCAN or DRAIN is a protocol violation. The block ignores it and continues.

## Timing
- Start accepted at cycle 0 → dump_busy=1 and table_hold_req=1 at cycle 1.
- Ack first seen high at cycle A → ram_rdaddr=0 registered at A+1 and valid at the RAM.
- Data for address 0 returns at A+1+RD_LAT, with dump_out_wr and ram_wren at A+2+RD_LAT.
- Without backpressure, the last address (4095) issues at A+4096.
- DRAIN lasts RD_LAT+1 cycles. dump_done pulses at A+4098+RD_LAT, and dump_busy falls in the same cycle.
- Each cycle with alf=1 during SCAN adds exactly one cycle to completion.
- Export order is strictly ascending bucket address.

## Test plan
- Empty table, ack tied high, no clear:
  - no dump_out_wr, no ram_wren, entry_cnt=0;
  - dump_done exactly 4098+RD_LAT cycles after ack is seen.
- Entries at 0, 7 and 4095 (e.g. {32'h0A000001, 32'd5, 32'd2}):
  - three exports in order {12'h000,…}, {12'h007,…}, {12'hFFF,…};
  - entry_cnt=3.
- Same table with dump_clear=1:
  - same three exports, 4096 ram_wren pulses with wrvalue=0;
  - a second dump exports nothing.
- dump_out_alf high for 50 cycles starting at bucket 100, with all buckets non-zero:
  - exactly 4096 exports, ascending with no gaps or repeats;
  - done delayed by 50 cycles;
  - entry_cnt=4096.
- table_hold_ack delayed 20 cycles:
  - no ram_rdaddr activity until 1 cycle after ack;
  - dump_start pulsed during SCAN is ignored.
- Reset asserted mid-SCAN:
  - all outputs 0 immediately, state IDLE, no dump_done;
  - a fresh start afterwards completes normally.

Source files
------------

// File: rtl/heavy_part_table_dump0.sv
// Heavy-part table 0 read-out engine: holds the compare stage, scans every bucket in
// address order, exports non-empty entries with their index and optionally zeroes the table.
module heavy_part_table_dump0 #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 96,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dump_start,
  input  logic                     dump_clear,
  output logic                     dump_busy,
  output logic                     dump_done,
  output logic [ADDR_W:0]          entry_cnt,
  output logic                     table_hold_req,
  input  logic                     table_hold_ack,
  output logic [ADDR_W-1:0]        ram_rdaddr,
  input  logic [DATA_W-1:0]        ram_rdvalue,
  output logic                     ram_wren,
  output logic [ADDR_W-1:0]        ram_wraddr,
  output logic [DATA_W-1:0]        ram_wrvalue,
  output logic                     dump_out_wr,
  output logic [ADDR_W+DATA_W-1:0] dump_out,
  input  logic                     dump_out_alf
);

  typedef enum logic [2:0] {IDLE, HOLD, SCAN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t                      state;
  logic                        clear_r;
  logic [ADDR_W-1:0]           issue_addr;
  logic [RD_LAT:0]             vld_pipe;
  logic [RD_LAT:0][ADDR_W-1:0] addr_pipe;
  logic                        issue;
  logic                        ret_vld;
  logic                        ret_nz;
  logic [ADDR_W-1:0]           ret_addr;

  // Address 0 goes out on the same edge that leaves HOLD, so the scan starts one
  // cycle after ack is seen. Almost-full only gates new reads.
  assign issue    = ((state == HOLD && table_hold_ack) || state == SCAN) && !dump_out_alf;
  assign ret_vld  = vld_pipe[RD_LAT];
  assign ret_addr = addr_pipe[RD_LAT];
  assign ret_nz   = (ram_rdvalue != '0);

  // Clearing always writes zero; the write enable/address carry all the timing.
  assign ram_wrvalue = '0;

  // Stage 0 lines up with ram_rdaddr, stage RD_LAT with ram_rdvalue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[RD_LAT-1:0], issue};
      addr_pipe <= {addr_pipe[RD_LAT-1:0], issue_addr};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      clear_r        <= 1'b0;
      issue_addr     <= '0;
      dump_busy      <= 1'b0;
      dump_done      <= 1'b0;
      entry_cnt      <= '0;
      table_hold_req <= 1'b0;
      ram_rdaddr     <= '0;
      ram_wren       <= 1'b0;
      ram_wraddr     <= '0;
      dump_out_wr    <= 1'b0;
      dump_out       <= '0;
    end else begin
      dump_done   <= 1'b0;
      dump_out_wr <= 1'b0;
      ram_wren    <= 1'b0;

      if (ret_vld) begin
        if (ret_nz) begin
          dump_out_wr <= 1'b1;
          dump_out    <= {ret_addr, ram_rdvalue};
          entry_cnt   <= entry_cnt + 1'b1;
        end
        if (clear_r) begin
          ram_wren   <= 1'b1;
          ram_wraddr <= ret_addr;
        end
      end

      if (issue) begin
        ram_rdaddr <= issue_addr;
        issue_addr <= issue_addr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (dump_start) begin
            state          <= HOLD;
            clear_r        <= dump_clear;
            entry_cnt      <= '0;
            issue_addr     <= '0;
            dump_busy      <= 1'b1;
            table_hold_req <= 1'b1;
          end
        end
        HOLD: begin
          if (table_hold_ack) state <= SCAN;
        end
        SCAN: begin
          if (issue && issue_addr == LAST_ADDR) state <= DRAIN;
        end
        DRAIN: begin
          // The read in the last stage is exported on this same edge.
          if (vld_pipe[RD_LAT-1:0] == '0) state <= DONE;
        end
        DONE: begin
          dump_done      <= 1'b1;
          dump_busy      <= 1'b0;
          table_hold_req <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heavy_part_table_dump0.sv
// Directed bench for heavy_part_table_dump0 with a 2-cycle-latency table RAM model.
module tb_heavy_part_table_dump0;
  localparam int RD_LAT   = 2;
  localparam int DUMP_LAT = 4098 + RD_LAT;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         dump_start = 1'b0;
  logic         dump_clear = 1'b0;
  logic         dump_busy, dump_done;
  logic [12:0]  entry_cnt;
  logic         table_hold_req;
  logic         table_hold_ack = 1'b1;
  logic [11:0]  ram_rdaddr;
  logic [95:0]  ram_rdvalue;
  logic         ram_wren;
  logic [11:0]  ram_wraddr;
  logic [95:0]  ram_wrvalue;
  logic         dump_out_wr;
  logic [107:0] dump_out;
  logic         dump_out_alf = 1'b0;

  heavy_part_table_dump0 #(.ADDR_W(12), .DATA_W(96), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .dump_start(dump_start), .dump_clear(dump_clear),
    .dump_busy(dump_busy), .dump_done(dump_done), .entry_cnt(entry_cnt),
    .table_hold_req(table_hold_req), .table_hold_ack(table_hold_ack),
    .ram_rdaddr(ram_rdaddr), .ram_rdvalue(ram_rdvalue), .ram_wren(ram_wren),
    .ram_wraddr(ram_wraddr), .ram_wrvalue(ram_wrvalue), .dump_out_wr(dump_out_wr),
    .dump_out(dump_out), .dump_out_alf(dump_out_alf)
  );

  always #5 clk = ~clk;

  localparam logic [95:0] E0 = {32'h0A000001, 32'd5, 32'd2};
  localparam logic [95:0] E7 = {32'h0A000007, 32'd9, 32'd1};
  localparam logic [95:0] EF = {32'hC0A80001, 32'd1, 32'd0};
  localparam logic [95:0] FV = {32'hDEAD0000, 32'd1, 32'd0};

  // Table RAM: registered address in, data out RD_LAT=2 cycles later.
  logic [95:0] mem [4096];
  logic [95:0] rd_p1;
  logic        fill_en = 1'b0, fill_xor = 1'b0, poke_en = 1'b0;
  logic [95:0] fill_val = '0, poke_data = '0;
  logic [11:0] poke_addr = '0;

  always @(posedge clk) begin
    rd_p1       <= mem[ram_rdaddr];
    ram_rdvalue <= rd_p1;
    if (fill_en) begin
      for (int i = 0; i < 4096; i++) mem[i] <= fill_xor ? (fill_val ^ 96'(i)) : fill_val;
    end else if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_wren) mem[ram_wraddr] <= ram_wrvalue;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [107:0] exp_q[$];
  int           exp_cyc_q[$];
  int           wren_cnt = 0, wr_nz = 0, done_cnt = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (dump_out_wr) begin
      exp_q.push_back(dump_out);
      exp_cyc_q.push_back(cyc);
    end
    if (ram_wren) begin
      wren_cnt <= wren_cnt + 1;
      if (ram_wrvalue != '0) wr_nz <= wr_nz + 1;
    end
    if (dump_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int pass_cnt = 0, chk_cnt = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill(input logic [95:0] v, input logic x);
    fill_val = v; fill_xor = x; fill_en = 1'b1;
    tick();
    fill_en = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [95:0] d);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic load_three();
    fill('0, 1'b0);
    poke(12'h000, E0);
    poke(12'h007, E7);
    poke(12'hFFF, EF);
  endtask

  task automatic start_dump(input logic clr, output int s);
    s = cyc;
    dump_start = 1'b1; dump_clear = clr;
    tick();
    dump_start = 1'b0; dump_clear = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    chk_cnt++;
    if ({dump_busy, dump_done, entry_cnt, table_hold_req, ram_rdaddr, ram_wren, ram_wraddr,
         ram_wrvalue, dump_out_wr, dump_out} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b cnt=%0d hold=%b wr=%b, want all 0",
               dump_busy, dump_done, entry_cnt, table_hold_req, dump_out_wr);
    else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_empty();
    int s, e0, w0; logic ok;
    fill('0, 1'b0);
    e0 = exp_q.size(); w0 = wren_cnt;
    start_dump(1'b0, s);
    chk_cnt++;
    if (dump_busy !== 1'b1 || table_hold_req !== 1'b1)
      $display("FAIL start_busy_hold: busy=%b hold=%b, want 1 1", dump_busy, table_hold_req);
    else pass_cnt++;
    wait_done(5000, ok);
    chk_cnt++;
    if (!ok) $display("FAIL empty_done_timeout: no dump_done within budget");
    else pass_cnt++;
    chk_cnt++;
    if (done_cyc - (s + 1) !== DUMP_LAT)
      $display("FAIL empty_latency: got %0d want %0d", done_cyc - (s + 1), DUMP_LAT);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() - e0 !== 0 || wren_cnt - w0 !== 0 || entry_cnt !== 13'd0)
      $display("FAIL empty_exports: exports=%0d wren=%0d cnt=%0d, want 0 0 0",
               exp_q.size() - e0, wren_cnt - w0, entry_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (dump_busy !== 1'b0 || table_hold_req !== 1'b0)
      $display("FAIL empty_idle: busy=%b hold=%b, want 0 0", dump_busy, table_hold_req);
    else pass_cnt++;
  endtask

  task automatic test_three(input logic clr);
    int s, e0, w0, n0; logic ok;
    e0 = exp_q.size(); w0 = wren_cnt; n0 = wr_nz;
    start_dump(clr, s);
    wait_done(5000, ok);
    chk_cnt++;
    if (!ok || exp_q.size() - e0 !== 3) begin
      $display("FAIL three_count clr=%0d: done=%b exports=%0d want 3", clr, ok, exp_q.size() - e0);
    end else begin
      pass_cnt++;
      chk_cnt++;
      if (exp_q[e0] !== {12'h000, E0} || exp_q[e0+1] !== {12'h007, E7} || exp_q[e0+2] !== {12'hFFF, EF})
        $display("FAIL three_data clr=%0d: got %h %h %h", clr, exp_q[e0], exp_q[e0+1], exp_q[e0+2]);
      else pass_cnt++;
      chk_cnt++;
      if (exp_cyc_q[e0] - s !== 3 + RD_LAT)
        $display("FAIL first_export_cycle: got %0d want %0d", exp_cyc_q[e0] - s, 3 + RD_LAT);
      else pass_cnt++;
    end
    chk_cnt++;
    if (entry_cnt !== 13'd3) $display("FAIL three_entry_cnt: got %0d want 3", entry_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (wren_cnt - w0 !== (clr ? 4096 : 0) || wr_nz - n0 !== 0)
      $display("FAIL three_wren clr=%0d: wren=%0d nz=%0d want %0d 0",
               clr, wren_cnt - w0, wr_nz - n0, clr ? 4096 : 0);
    else pass_cnt++;
  endtask

  task automatic test_after_clear();
    int s, e0; logic ok;
    e0 = exp_q.size();
    start_dump(1'b0, s);
    wait_done(5000, ok);
    chk_cnt++;
    if (!ok || exp_q.size() - e0 !== 0 || entry_cnt !== 13'd0)
      $display("FAIL after_clear: done=%b exports=%0d cnt=%0d want 1 0 0",
               ok, exp_q.size() - e0, entry_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int s, a, e0, bad, n; logic ok;
    logic [107:0] want;
    fill(FV, 1'b1);
    e0 = exp_q.size();
    start_dump(1'b0, s);
    a = s + 1;
    while (cyc < a + 100) tick();
    dump_out_alf = 1'b1;
    repeat (50) tick();
    dump_out_alf = 1'b0;
    wait_done(5000, ok);
    chk_cnt++;
    if (!ok || done_cyc - a !== DUMP_LAT + 50)
      $display("FAIL bp_latency: done=%b got %0d want %0d", ok, done_cyc - a, DUMP_LAT + 50);
    else pass_cnt++;
    n = exp_q.size() - e0;
    chk_cnt++;
    if (n !== 4096) $display("FAIL bp_count: got %0d want 4096", n);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 4096 && k < n; k++) begin
      want = {12'(k), FV ^ 96'(k)};
      if (exp_q[e0+k] !== want) bad++;
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL bp_order: %0d wrong exports, want 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (entry_cnt !== 13'd4096) $display("FAIL bp_entry_cnt: got %0d want 4096", entry_cnt);
    else pass_cnt++;
  endtask

  task automatic test_ack_delay();
    int s, a, e0, d0, bad; logic ok;
    load_three();
    table_hold_ack = 1'b0;
    e0 = exp_q.size(); d0 = done_cnt;
    start_dump(1'b0, s);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ram_rdaddr !== 12'hFFF || table_hold_req !== 1'b1) bad++;
      tick();
    end
    chk_cnt++;
    if (bad !== 0 || exp_q.size() !== e0)
      $display("FAIL ack_wait_quiet: %0d bad cycles, %0d exports, want 0 0", bad, exp_q.size() - e0);
    else pass_cnt++;
    a = cyc;
    table_hold_ack = 1'b1;
    tick();
    chk_cnt++;
    if (ram_rdaddr !== 12'h000) $display("FAIL ack_first_addr: got %h want 000", ram_rdaddr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (ram_rdaddr !== 12'h001) $display("FAIL ack_second_addr: got %h want 001", ram_rdaddr);
    else pass_cnt++;
    while (cyc < a + 100) tick();
    dump_start = 1'b1; dump_clear = 1'b1;
    tick();
    dump_start = 1'b0; dump_clear = 1'b0;
    wait_done(5000, ok);
    chk_cnt++;
    if (!ok || done_cyc - a !== DUMP_LAT)
      $display("FAIL ack_latency: done=%b got %0d want %0d", ok, done_cyc - a, DUMP_LAT);
    else pass_cnt++;
    repeat (10) tick();
    chk_cnt++;
    if (done_cnt - d0 !== 1 || dump_busy !== 1'b0 || exp_q.size() - e0 !== 3)
      $display("FAIL ignored_start: dones=%0d busy=%b exports=%0d want 1 0 3",
               done_cnt - d0, dump_busy, exp_q.size() - e0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int s, d0, e0; logic ok;
    start_dump(1'b0, s);
    while (cyc < s + 200) tick();
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk_cnt++;
    if ({dump_busy, dump_done, entry_cnt, table_hold_req, ram_rdaddr, ram_wren, ram_wraddr,
         dump_out_wr, dump_out} !== '0)
      $display("FAIL mid_reset_outputs: busy=%b hold=%b cnt=%0d addr=%h, want all 0",
               dump_busy, table_hold_req, entry_cnt, ram_rdaddr);
    else pass_cnt++;
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk_cnt++;
    if (done_cnt !== d0 || dump_busy !== 1'b0 || table_hold_req !== 1'b0)
      $display("FAIL mid_reset_idle: dones=%0d busy=%b hold=%b want 0 0 0",
               done_cnt - d0, dump_busy, table_hold_req);
    else pass_cnt++;
    e0 = exp_q.size();
    start_dump(1'b0, s);
    wait_done(5000, ok);
    chk_cnt++;
    if (!ok || done_cyc - (s + 1) !== DUMP_LAT || exp_q.size() - e0 !== 3 || entry_cnt !== 13'd3)
      $display("FAIL restart: done=%b lat=%0d exports=%0d cnt=%0d want 1 %0d 3 3",
               ok, done_cyc - (s + 1), exp_q.size() - e0, entry_cnt, DUMP_LAT);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_empty();
    load_three();
    test_three(1'b0);
    test_three(1'b1);
    test_after_clear();
    test_backpressure();
    test_ack_delay();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
